// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM word-port arbiter.
package sdram_arb_pkg;

    localparam int DEFAULT_ADDR_W = 23;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational round-robin picker: first requesting port at or after rr_ptr, with wrap.
// With SDRAM_ARB_PRIO_EN defined, port 0 overrides the rotation whenever prio_en is set.
module sdram_arb_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
`ifdef SDRAM_ARB_PRIO_EN
    input  logic             prio_en,
`endif
    output logic             found,
    output logic [PTR_W-1:0] index
);

    logic [PTR_W:0] cand;

    // Scan offsets from farthest to nearest so the port closest to rr_ptr is the last writer.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(N)) begin
                cand = cand - (PTR_W + 1)'(N);
            end
            if (req[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                index = cand[PTR_W-1:0];
            end
        end
`ifdef SDRAM_ARB_PRIO_EN
        if (prio_en && req[0]) begin
            found = 1'b1;
            index = '0;
        end
`endif
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter serialising N requester cores onto the single SDRAMBus word port.
// Define SDRAM_ARB_PRIO_EN to give port 0 fixed highest priority over the rotation.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N-1:0]           req_read,
    input  logic [N-1:0]           req_write,
    input  logic [N*ADDR_W-1:0]    req_addr,
    input  logic [N*DATA_W-1:0]    req_writedata,
    output logic [DATA_W-1:0]      req_readdata,
    output logic [N-1:0]           req_finished,
    output logic                   sdram_read,
    output logic                   sdram_write,
    output logic [ADDR_W-1:0]      sdram_addr,
    output logic [DATA_W-1:0]      sdram_writedata,
    input  logic [DATA_W-1:0]      sdram_readdata,
    input  logic                   sdram_finished,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N);

    state_t             state, state_n;
    op_t                op, op_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]   grant_n, next_ptr;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  wdata_n, rdata_n;
    logic [N-1:0]       fin_n;
    logic               rd_n, wr_n, busy_n;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;

    sdram_arb_rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req_read | req_write),
        .rr_ptr (rr_ptr),
`ifdef SDRAM_ARB_PRIO_EN
        .prio_en(1'b1),
`endif
        .found  (pick_found),
        .index  (pick_idx)
    );

    assign next_ptr = (grant_id == PTR_W'(N - 1)) ? '0 : grant_id + PTR_W'(1);

    // Every output is a register, so the next-state logic computes next values for all of them.
    always_comb begin
        state_n = state;
        op_n    = op;
        rr_ptr_n = rr_ptr;
        grant_n = grant_id;
        addr_n  = sdram_addr;
        wdata_n = sdram_writedata;
        rdata_n = req_readdata;
        rd_n    = sdram_read;
        wr_n    = sdram_write;
        fin_n   = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_n = pick_idx;
                    addr_n  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_n = req_writedata[int'(pick_idx)*DATA_W +: DATA_W];
                    op_n    = req_write[pick_idx] ? OP_WRITE : OP_READ;
                    wr_n    = req_write[pick_idx];
                    rd_n    = !req_write[pick_idx];
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (sdram_finished) begin
                    rd_n = 1'b0;
                    wr_n = 1'b0;
                    if (op == OP_READ) begin
                        rdata_n = sdram_readdata;
                    end
                    fin_n[grant_id] = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
`ifdef SDRAM_ARB_PRIO_EN
                if (grant_id != '0) begin
                    rr_ptr_n = next_ptr;
                end
`else
                rr_ptr_n = next_ptr;
`endif
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            op              <= OP_READ;
            rr_ptr          <= '0;
            grant_id        <= '0;
            sdram_addr      <= '0;
            sdram_writedata <= '0;
            sdram_read      <= 1'b0;
            sdram_write     <= 1'b0;
            req_readdata    <= '0;
            req_finished    <= '0;
            busy            <= 1'b0;
        end else begin
            state           <= state_n;
            op              <= op_n;
            rr_ptr          <= rr_ptr_n;
            grant_id        <= grant_n;
            sdram_addr      <= addr_n;
            sdram_writedata <= wdata_n;
            sdram_read      <= rd_n;
            sdram_write     <= wr_n;
            req_readdata    <= rdata_n;
            req_finished    <= fin_n;
            busy            <= busy_n;
        end
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Round-robin arbiter sharing the single SDRAMBus word port (sdram_addr/read/write/writedata/readdata/finished) among N requester cores (record, play, mix, pitch, loaddata).
- Replaces the control-mode multiplexer, so that concurrent cores (e.g. record while play) each get serialized single-word SDRAM transactions.
- Sits between the core instances and SDRAMBus inside the top-level core.

Parameters:
- N, 4, number of requester ports (2..8).
- ADDR_W, 23, SDRAM word address width.
- DATA_W, 32, SDRAM data width.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- req_read  in  N  per-requester read request; level, held until finished.
- req_write  in  N  per-requester write request; level, held until finished.
- req_addr  in  N*ADDR_W  packed; slice k belongs to requester k.
- req_writedata  in  N*DATA_W  packed; slice k belongs to requester k.
- req_readdata  out  DATA_W  registered read data, broadcast to all requesters.
- req_finished  out  N  one-cycle, one-hot completion pulse.
- sdram_read  out  1  to SDRAMBus.
- sdram_write  out  1  to SDRAMBus.
- sdram_addr  out  ADDR_W  to SDRAMBus.
- sdram_writedata  out  DATA_W  to SDRAMBus.
- sdram_readdata  in  DATA_W  from SDRAMBus.
- sdram_finished  in  1  from SDRAMBus; one-cycle pulse ending a transaction.
- grant_id  out  $clog2(N)  index of the current or last granted port.
- busy  out  1  high in GRANT and DONE states.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all outputs 0 (sdram_*, req_finished, req_readdata, grant_id, busy).
- All outputs are registered.
- States:
  - IDLE: if any req_read|req_write, pick the first requesting port searching from rr_ptr upward with wrap-around; latch g, addr and writedata; set op=write if req_write[g] else read; go to GRANT. Otherwise stay in IDLE.
  - GRANT: drive sdram_read/sdram_write (per op), sdram_addr and sdram_writedata from the latched values, held constant. On sdram_finished, deassert sdram_read/write at the next edge, capture req_readdata=sdram_readdata (read only; unchanged on write), and go to DONE.
  - DONE (exactly 1 cycle): req_finished[g]=1, rr_ptr=(g+1) mod N, then go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle t; sdram strobe is high from cycle t+1.
  - sdram_finished in cycle f gives req_finished[g] and valid req_readdata in cycle f+1; the next arbitration happens in cycle f+2.
  - Minimum transaction spacing is 3 cycles plus SDRAMBus latency.
- Requester contract:
  - Requests are held until finished; the requester drops or changes its request at the edge ending the finished cycle.
  - The DONE cycle guarantees no double service.
  - req_readdata is valid during the finished cycle and holds until the next read completes.
- Read and write both high on one port: write wins; read is ignored for that grant.
- Request withdrawn mid-GRANT: the transaction still completes and req_finished still pulses.
- sdram_finished outside GRANT: ignored.
- Simultaneous requests: the port nearest rr_ptr (with wrap) wins. Every requesting port is served within N grants (no starvation).
- i_rst mid-transaction: at the next edge all outputs return to 0 and state goes to IDLE. Any pending SDRAMBus completion is ignored.

Optional Feature:
- Macro SDRAM_ARB_PRIO_EN.
- Defined: port 0 (audio-critical, play/record) is fixed highest priority. Whenever req_read[0]|req_write[0] is high in IDLE it is granted regardless of rr_ptr, and rr_ptr is not advanced by port-0 grants. Other ports remain round-robin among themselves.
- Undefined: pure round-robin over all N ports.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, GRANT, DONE};
  - default ADDR_W=23 and DATA_W=32 localparams;
  - op enum {OP_READ, OP_WRITE}.
- One combinational sub-module sdram_arb_rr_pick: inputs req vector, rr_ptr and (under the macro) priority enable; outputs found and index.

Test Plan:
- Single read: port 2 req_read, addr=23'h000100; SDRAMBus model returns 32'hDEADBEEF with finished 4 cycles after the strobe. Expect:
  - sdram_read=1 and sdram_addr=0x100 from t+1;
  - req_finished=4'b0100 for exactly 1 cycle, with req_readdata=DEADBEEF.
- Single write: port 1 req_write, addr=0x2A, data=0x12345678. Expect:
  - sdram_write=1 and sdram_writedata=0x12345678 held stable until finished;
  - req_readdata unchanged; req_finished=4'b0010.
- Contention: ports 0–3 all request continuously from reset. Expect grant order 0,1,2,3,0,… and each req_finished spaced 3 cycles plus bus latency apart.
- Read and write both asserted on port 3: only sdram_write is driven; exactly one req_finished[3] pulse.
- Reset mid-GRANT: assert i_rst while sdram_read=1. Expect:
  - next cycle all outputs 0 and state IDLE;
  - a late sdram_finished produces no req_finished pulse.
- SDRAM_ARB_PRIO_EN: ports 0 and 2 request continuously. Expect port 0 granted every arbitration and port 2 never granted. With the macro undefined, grants alternate 0,2,0,2.
